// File: rtl/cnn_pkg.sv
// Shared widths, frame sizes and sequencer state encoding for the CNN layer feeder.
// Imported by the feeder interface, the result FIFO user and the top.
package cnn_pkg;

    localparam int IMG_W       = 4;
    localparam int FLT_W       = 4;
    localparam int RES_W       = 10;
    localparam int NUM_PAIRS   = 15;
    localparam int NUM_RESULTS = NUM_PAIRS / 3;
    localparam int RES_LAT     = 2;

    localparam int PAIR_CW = $clog2(NUM_PAIRS + 1);
    localparam int RES_CW  = $clog2(NUM_RESULTS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_READ,
        S_DRAIN
    } feeder_state_t;

    typedef struct packed {
        logic [IMG_W-1:0]        img;
        logic signed [FLT_W-1:0] flt;
    } pair_t;

endpackage

// File: rtl/cnn_layer_feeder_if.sv
// Load, layer and result ports of the feeder; master is the feeder side.
// CNN_FEEDER_ZERO_CNT_EN adds the zero_cnt status output.
interface cnn_layer_feeder_if;
    import cnn_pkg::*;

    logic                    ld_valid;
    logic                    ld_ready;
    logic [IMG_W-1:0]        ld_image;
    logic signed [FLT_W-1:0] ld_filter;
    logic                    go;
    logic                    Start;
    logic [IMG_W-1:0]        Image;
    logic signed [FLT_W-1:0] Filter;
    logic                    ReadEn;
    logic signed [RES_W-1:0] ConvResult;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [RES_W-1:0] res_data;
    logic                    busy;
    logic                    done;
`ifdef CNN_FEEDER_ZERO_CNT_EN
    logic [2:0]              zero_cnt;

    modport master (
        input  ld_valid, ld_image, ld_filter, go, ConvResult, res_ready,
        output ld_ready, Start, Image, Filter, ReadEn,
        output res_valid, res_data, busy, done, zero_cnt
    );

    modport slave (
        output ld_valid, ld_image, ld_filter, go, ConvResult, res_ready,
        input  ld_ready, Start, Image, Filter, ReadEn,
        input  res_valid, res_data, busy, done, zero_cnt
    );
`else
    modport master (
        input  ld_valid, ld_image, ld_filter, go, ConvResult, res_ready,
        output ld_ready, Start, Image, Filter, ReadEn,
        output res_valid, res_data, busy, done
    );

    modport slave (
        output ld_valid, ld_image, ld_filter, go, ConvResult, res_ready,
        input  ld_ready, Start, Image, Filter, ReadEn,
        input  res_valid, res_data, busy, done
    );
`endif

endinterface

// File: rtl/cnn_result_fifo.sv
// Small synchronous FIFO with arbitrary depth; head word is visible combinationally.
module cnn_result_fifo #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 10,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wrap(wr_q);
            end
            if (do_pop) begin
                rd_q <= wrap(rd_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cnn_layer_feeder.sv
// Frame sequencer: buffers 15 pairs, plays them into the conv layer, collects results.
// Define CNN_FEEDER_ZERO_CNT_EN to add the per-frame zero-result counter.
module cnn_layer_feeder
    import cnn_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    cnn_layer_feeder_if.master bus
);

    feeder_state_t           state_q;
    pair_t                   pair_q [NUM_PAIRS];
    logic [PAIR_CW-1:0]      ld_cnt_q;
    logic [PAIR_CW-1:0]      wr_idx_q;
    logic [RES_CW-1:0]       rd_cnt_q;
    logic [RES_CW-1:0]       push_cnt_q;
    logic                    start_q;
    logic                    rden_q;
    logic                    busy_q;
    logic                    done_q;
    logic [IMG_W-1:0]        image_q;
    logic signed [FLT_W-1:0] filter_q;
    logic [RES_LAT-1:0]      vpipe_q;

    logic                    ld_fire;
    logic                    go_fire;
    logic                    push;
    logic                    pop;
    logic                    drain_done;
    logic                    fifo_empty;
    logic [RES_CW-1:0]       fifo_cnt;
    logic [RES_W-1:0]        fifo_rdata;

    assign bus.ld_ready  = (state_q == S_IDLE) &&
                           (ld_cnt_q < PAIR_CW'(NUM_PAIRS));
    assign ld_fire       = bus.ld_valid & bus.ld_ready;
    assign go_fire       = (state_q == S_IDLE) & bus.go &
                           (ld_cnt_q == PAIR_CW'(NUM_PAIRS));
    assign push          = vpipe_q[RES_LAT-1] &
                           ((state_q == S_READ) | (state_q == S_DRAIN));
    assign pop           = bus.res_valid & bus.res_ready;
    // Leave DRAIN on the edge that empties the FIFO, not one cycle later.
    assign drain_done    = (push_cnt_q == RES_CW'(NUM_RESULTS)) && !push &&
                           (fifo_cnt == RES_CW'(pop));

    assign bus.Start     = start_q;
    assign bus.Image     = image_q;
    assign bus.Filter    = filter_q;
    assign bus.ReadEn    = rden_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_valid = !fifo_empty;
    assign bus.res_data  = fifo_rdata;

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            pair_q[ld_cnt_q] <= '{img: bus.ld_image, flt: bus.ld_filter};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q <= (vpipe_q << 1) | RES_LAT'(rden_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ld_cnt_q   <= '0;
            wr_idx_q   <= '0;
            rd_cnt_q   <= '0;
            push_cnt_q <= '0;
            start_q    <= 1'b0;
            rden_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            image_q    <= '0;
            filter_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (ld_fire) begin
                ld_cnt_q <= ld_cnt_q + 1'b1;
            end
            if (push) begin
                push_cnt_q <= push_cnt_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (go_fire) begin
                        state_q    <= S_WRITE;
                        busy_q     <= 1'b1;
                        start_q    <= 1'b1;
                        image_q    <= pair_q[0].img;
                        filter_q   <= pair_q[0].flt;
                        wr_idx_q   <= PAIR_CW'(1);
                        push_cnt_q <= '0;
                    end
                end
                S_WRITE: begin
                    if (wr_idx_q == PAIR_CW'(NUM_PAIRS)) begin
                        state_q  <= S_GAP;
                        start_q  <= 1'b0;
                        image_q  <= '0;
                        filter_q <= '0;
                    end else begin
                        image_q  <= pair_q[wr_idx_q].img;
                        filter_q <= pair_q[wr_idx_q].flt;
                        wr_idx_q <= wr_idx_q + 1'b1;
                    end
                end
                S_GAP: begin
                    state_q  <= S_READ;
                    rden_q   <= 1'b1;
                    rd_cnt_q <= RES_CW'(1);
                end
                S_READ: begin
                    if (rd_cnt_q == RES_CW'(NUM_RESULTS)) begin
                        state_q <= S_DRAIN;
                        rden_q  <= 1'b0;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        ld_cnt_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CNN_FEEDER_ZERO_CNT_EN
    logic [2:0] zero_cnt_q;

    assign bus.zero_cnt = zero_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt_q <= '0;
        end else if (go_fire) begin
            zero_cnt_q <= '0;
        end else if (push && (bus.ConvResult == '0)) begin
            zero_cnt_q <= zero_cnt_q + 1'b1;
        end
    end
`endif

    cnn_result_fifo #(
        .DEPTH (NUM_RESULTS),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (bus.ConvResult),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

endmodule
